// File: rtl/dec8_rr_arbiter.sv
// rtl/dec8_rr_arbiter.sv - round-robin arbiter sharing one 3-to-8 decoder stage among eight requesters
module dec8_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  output logic [2:0] sel_o,
  output logic       en_o,
  output logic [7:0] gnt_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          timeout_q, timeout_d;
  logic          en_q, en_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;

  logic          win_found;
  logic [2:0]    win_idx;

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit is the winner.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr_q + 3'(k);
      if (req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          sel_d   = win_idx;
          cnt_d   = CNT_ONE;
        end
      end
      S_GRANT: begin
        if (!req_i[sel_q]) begin
          state_d = S_GAP;
          ptr_d   = sel_q;
        end else if (cnt_q == HOLD_LIM) begin
          state_d   = S_GAP;
          ptr_d     = sel_q;
          timeout_d = 1'b1;
        end else if (cnt_q < HOLD_LIM) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (win_found) begin
          state_d = S_GRANT;
          sel_d   = win_idx;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next state so they are registered yet aligned with the state.
  always_comb begin
    en_d   = (state_d == S_GRANT);
    gnt_d  = en_d ? (8'b1 << sel_d) : 8'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd7;
      cnt_q     <= '0;
      sel_q     <= 3'd0;
      timeout_q <= 1'b0;
      en_q      <= 1'b0;
      gnt_q     <= 8'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      en_q      <= en_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  assign sel_o     = sel_q;
  assign en_o      = en_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
